// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, ALU codes, mux selects,
// immediate formats and opcodes, plus the branch-condition helper.
package riscv_ctrl_pkg;

   typedef logic [3:0] state_t;
   localparam state_t StFetch    = 4'd0;
   localparam state_t StDecode   = 4'd1;
   localparam state_t StMemAdr   = 4'd2;
   localparam state_t StMemRead  = 4'd3;
   localparam state_t StMemWb    = 4'd4;
   localparam state_t StMemWrite = 4'd5;
   localparam state_t StExecR    = 4'd6;
   localparam state_t StExecI    = 4'd7;
   localparam state_t StAluWb    = 4'd8;
   localparam state_t StBranch   = 4'd9;
   localparam state_t StJalrAdr  = 4'd10;
   localparam state_t StJump     = 4'd11;
   localparam state_t StLui      = 4'd12;
   localparam state_t StAuipc    = 4'd13;
   localparam state_t StTrap     = 4'd14;

   localparam logic [3:0] AluAdd  = 4'b0000;
   localparam logic [3:0] AluSub  = 4'b0001;
   localparam logic [3:0] AluAnd  = 4'b0010;
   localparam logic [3:0] AluOr   = 4'b0011;
   localparam logic [3:0] AluXor  = 4'b0100;
   localparam logic [3:0] AluSlt  = 4'b0101;
   localparam logic [3:0] AluSltu = 4'b0110;
   localparam logic [3:0] AluSll  = 4'b0111;
   localparam logic [3:0] AluSrl  = 4'b1000;
   localparam logic [3:0] AluSra  = 4'b1001;

   localparam logic [1:0] AluOpAdd   = 2'b00;
   localparam logic [1:0] AluOpSub   = 2'b01;
   localparam logic [1:0] AluOpFunct = 2'b10;

   localparam logic [1:0] SrcAPc    = 2'b00;
   localparam logic [1:0] SrcAOldPc = 2'b01;
   localparam logic [1:0] SrcARd1   = 2'b10;
   localparam logic [1:0] SrcAZero  = 2'b11;

   localparam logic [1:0] SrcBRd2  = 2'b00;
   localparam logic [1:0] SrcBImm  = 2'b01;
   localparam logic [1:0] SrcBFour = 2'b10;

   localparam logic [1:0] ResAluOut    = 2'b00;
   localparam logic [1:0] ResData      = 2'b01;
   localparam logic [1:0] ResAluResult = 2'b10;

   localparam logic [2:0] ImmI = 3'b000;
   localparam logic [2:0] ImmS = 3'b001;
   localparam logic [2:0] ImmB = 3'b010;
   localparam logic [2:0] ImmJ = 3'b011;
   localparam logic [2:0] ImmU = 3'b100;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpI      = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   // Flags come from a-b; carry is the carry-out of a+~b+1, so carry=1 means a>=b unsigned.
   function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                         input logic neg, input logic ovf, input logic carry);
      logic taken;
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = neg ^ ovf;
         3'b101:  taken = ~(neg ^ ovf);
         3'b110:  taken = ~carry;
         3'b111:  taken = carry;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus instruction fields to the 4-bit ALU operation code.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic       op5,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [3:0] alu_control
);

   always_comb begin
      alu_control = AluAdd;
      case (alu_op)
         AluOpSub: alu_control = AluSub;
         AluOpFunct: begin
            case (funct3)
               // Only R-type carries funct7; for I-type bit 30 belongs to the immediate.
               3'b000:  alu_control = (op5 & funct7b5) ? AluSub : AluAdd;
               3'b001:  alu_control = AluSll;
               3'b010:  alu_control = AluSlt;
               3'b011:  alu_control = AluSltu;
               3'b100:  alu_control = AluXor;
               3'b101:  alu_control = funct7b5 ? AluSra : AluSrl;
               3'b110:  alu_control = AluOr;
               default: alu_control = AluAnd;
            endcase
         end
         default: alu_control = AluAdd;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and drives
// the datapath enables and mux selects, with memory wait states and illegal-opcode trapping.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter bit ILLEGAL_TRAP  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       neg,
   input  logic       ovf,
   input  logic       carry,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       mem_write,
   output logic       mem_read,
   output logic       adr_src,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] imm_src,
   output logic [3:0] alu_control,
   output logic       illegal,
   output logic [3:0] state_o
);

   state_t     state_q, state_d;
   logic [1:0] alu_op;
   logic       rdy;

   assign rdy     = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign state_o = state_q;

   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      adr_src    = 1'b0;
      result_src = ResAluOut;
      alu_src_a  = SrcAPc;
      alu_src_b  = SrcBRd2;
      imm_src    = ImmI;
      alu_op     = AluOpAdd;
      illegal    = 1'b0;
      case (state_q)
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = SrcBFour;
            ir_write  = rdy;
            pc_write  = rdy;
            if (rdy) state_d = StDecode;
         end
         StDecode: begin
            alu_src_a = SrcAOldPc;
            alu_src_b = SrcBImm;
            imm_src   = ImmB;
            case (op)
               OpLoad, OpStore: state_d = StMemAdr;
               OpR:             state_d = StExecR;
               OpI:             state_d = StExecI;
               OpBranch:        state_d = StBranch;
               OpJal:           state_d = StJump;
               OpJalr:          state_d = StJalrAdr;
               OpLui:           state_d = StLui;
               OpAuipc:         state_d = StAuipc;
               default:         state_d = ILLEGAL_TRAP ? StTrap : StFetch;
            endcase
         end
         StMemAdr: begin
            alu_src_a = SrcARd1;
            alu_src_b = SrcBImm;
            // op[5] separates store (0100011) from load (0000011).
            imm_src   = op[5] ? ImmS : ImmI;
            state_d   = op[5] ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            adr_src  = 1'b1;
            mem_read = 1'b1;
            if (rdy) state_d = StMemWb;
         end
         StMemWb: begin
            result_src = ResData;
            reg_write  = 1'b1;
            state_d    = StFetch;
         end
         StMemWrite: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            if (rdy) state_d = StFetch;
         end
         StExecR, StExecI: begin
            alu_src_a = SrcARd1;
            alu_src_b = (state_q == StExecI) ? SrcBImm : SrcBRd2;
            alu_op    = AluOpFunct;
            state_d   = StAluWb;
         end
         StAluWb: begin
            reg_write = 1'b1;
            state_d   = StFetch;
         end
         StBranch: begin
            alu_src_a = SrcARd1;
            alu_op    = AluOpSub;
            pc_write  = branch_taken(funct3, zero, neg, ovf, carry);
            state_d   = StFetch;
         end
         StJalrAdr: begin
            alu_src_a = SrcARd1;
            alu_src_b = SrcBImm;
            state_d   = StJump;
         end
         StJump: begin
            pc_write  = 1'b1;
            alu_src_a = SrcAOldPc;
            alu_src_b = SrcBFour;
            state_d   = StAluWb;
         end
         StLui, StAuipc: begin
            alu_src_a = (state_q == StLui) ? SrcAZero : SrcAOldPc;
            alu_src_b = SrcBImm;
            imm_src   = ImmU;
            state_d   = StAluWb;
         end
         StTrap: begin
            illegal = 1'b1;
         end
         default: state_d = StFetch;
      endcase
      if (reset) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= StFetch;
      else       state_q <= state_d;
   end

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .op5         (op[5]),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .alu_control (alu_control)
   );

endmodule
